// File: rtl/issue2_dispatch_alloc_if.sv
// Handshake bundle for issue2_dispatch_alloc. The stat_* members and STAT_W exist only
// when ISSUE2_ALLOC_STATS_EN is defined.
interface issue2_dispatch_alloc_if
`ifdef ISSUE2_ALLOC_STATS_EN
  #(parameter int STAT_W = 32)
`endif
  ;
  logic [1:0]   push_valid;
  logic [127:0] push_entry;
  logic [1:0]   push_ready;
  logic         pi_valid;
  logic [63:0]  pi_entry;
  logic         pi_ready;
  logic         i2_valid;
  logic [63:0]  i2_entry;
  logic         i2_ready;
  logic         wb_valid;
  logic [5:0]   wb_addr;
  logic         flush;
  logic [63:0]  sb_pending;
`ifdef ISSUE2_ALLOC_STATS_EN
  logic [STAT_W-1:0] stat_dual;
  logic [STAT_W-1:0] stat_single;
  logic [STAT_W-1:0] stat_stall;
`endif

  modport master (
    output push_valid, push_entry, pi_ready, i2_ready, wb_valid, wb_addr, flush,
    input  push_ready, pi_valid, pi_entry, i2_valid, i2_entry, sb_pending
`ifdef ISSUE2_ALLOC_STATS_EN
    , input stat_dual, stat_single, stat_stall
`endif
  );

  modport slave (
    input  push_valid, push_entry, pi_ready, i2_ready, wb_valid, wb_addr, flush,
    output push_ready, pi_valid, pi_entry, i2_valid, i2_entry, sb_pending
`ifdef ISSUE2_ALLOC_STATS_EN
    , output stat_dual, stat_single, stat_stall
`endif
  );
endinterface

// File: rtl/issue2_dispatch_alloc.sv
// Dual-issue dispatch allocator: 4-entry FIFO feeding pi (head) and i2 (head+1) lanes with a
// load scoreboard. Optional ISSUE2_ALLOC_STATS_EN adds saturating dual/single/stall counters.
module issue2_dispatch_alloc #(
  parameter int FPU = 0
`ifdef ISSUE2_ALLOC_STATS_EN
  , parameter int STAT_W = 32
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  issue2_dispatch_alloc_if.slave bus
);

  logic [63:0] fifo_mem [4];
  logic [1:0]  head;
  logic [2:0]  count;
  logic [63:0] sb;
  logic [63:0] sb_next;

  logic [63:0] head_e;
  logic [63:0] head1_e;
  logic [1:0]  tail;
  logic        pi_fire;
  logic        i2_fire;
  logic        push0;
  logic        push1;
  logic [1:0]  n_pop;
  logic [1:0]  n_push;
  logic [5:0]  i2_wd;
  logic [5:0]  i2_rd;

  // Without an FPU the upper register bank does not exist, so bit5 aliases to the integer file.
  function automatic logic [5:0] eaddr(input logic [5:0] a);
    return (FPU != 0) ? a : {1'b0, a[4:0]};
  endfunction

  function automatic logic hazard(input logic [63:0] e, input logic [63:0] s);
    logic [5:0] ra;
    logic [5:0] rb;
    logic [5:0] rc;
    logic [5:0] wa;
    ra = eaddr(e[37:32]);
    rb = eaddr(e[43:38]);
    rc = eaddr(e[49:44]);
    wa = eaddr(e[55:50]);
    return (e[56] && ra != 6'd0 && s[ra]) ||
           (e[57] && rb != 6'd0 && s[rb]) ||
           (e[58] && rc != 6'd0 && s[rc]) ||
           (e[59] && s[wa]) ||
           (e[61] && s[ra]);
  endfunction

  // True when entry e reads or writes register d.
  function automatic logic touches(input logic [63:0] e, input logic [5:0] d);
    return (e[56] && eaddr(e[37:32]) == d) ||
           (e[57] && eaddr(e[43:38]) == d) ||
           (e[58] && eaddr(e[49:44]) == d) ||
           ((e[59] || e[60]) && eaddr(e[55:50]) == d) ||
           (e[61] && eaddr(e[37:32]) == d);
  endfunction

  function automatic logic intra_dep(input logic [63:0] h0, input logic [63:0] h1);
    logic [5:0] d0;
    logic [5:0] d1;
    d0 = eaddr(h0[55:50]);
    d1 = eaddr(h0[37:32]);
    return ((h0[59] || h0[60]) && d0 != 6'd0 && touches(h1, d0)) ||
           (h0[61] && d1 != 6'd0 && touches(h1, d1));
  endfunction

  assign head_e  = fifo_mem[head];
  assign head1_e = fifo_mem[head + 2'd1];
  assign tail    = head + count[1:0];

  assign bus.push_ready = (rst || bus.flush) ? 2'b00 : {count <= 3'd2, count <= 3'd3};
  assign bus.pi_valid   = (count != 3'd0) && !hazard(head_e, sb) && !bus.flush;
  // Combinational on pi_ready so i2 can never overtake the head.
  assign bus.i2_valid   = bus.pi_valid && bus.pi_ready && (count >= 3'd2) &&
                          head_e[62] && head1_e[63] && !hazard(head1_e, sb) &&
                          !intra_dep(head_e, head1_e);
  assign bus.pi_entry   = head_e;
  assign bus.i2_entry   = head1_e;
  assign bus.sb_pending = sb;

  assign pi_fire = bus.pi_valid && bus.pi_ready;
  assign i2_fire = bus.i2_valid && bus.i2_ready;
  assign push0   = bus.push_valid[0] && bus.push_ready[0];
  assign push1   = bus.push_valid[0] && bus.push_valid[1] && bus.push_ready[1];
  assign n_pop   = {1'b0, pi_fire} + {1'b0, i2_fire};
  assign n_push  = {1'b0, push0} + {1'b0, push1};
  assign i2_wd   = eaddr(head1_e[55:50]);
  assign i2_rd   = eaddr(head1_e[37:32]);

  // Writeback clears first so a same-cycle set on the same register wins.
  always_comb begin
    sb_next = sb;
    if (bus.wb_valid) sb_next[eaddr(bus.wb_addr)] = 1'b0;
    if (i2_fire && head1_e[59]) begin
      if (i2_wd != 6'd0) sb_next[i2_wd] = 1'b1;
      if (head1_e[61] && i2_rd != 6'd0) sb_next[i2_rd] = 1'b1;
    end
    sb_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push0) fifo_mem[tail] <= bus.push_entry[63:0];
    if (push1) fifo_mem[tail + 2'd1] <= bus.push_entry[127:64];
  end

  // Scoreboard survives flush: loads already on i2 still write back.
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= 2'd0;
      count <= 3'd0;
      sb    <= 64'd0;
    end else begin
      if (bus.flush) begin
        count <= 3'd0;
      end else begin
        head  <= head + n_pop;
        count <= count - {1'b0, n_pop} + {1'b0, n_push};
      end
      sb <= sb_next;
    end
  end

`ifdef ISSUE2_ALLOC_STATS_EN
  localparam logic [STAT_W-1:0] STAT_ONE = STAT_W'(1);
  logic [STAT_W-1:0] stat_dual;
  logic [STAT_W-1:0] stat_single;
  logic [STAT_W-1:0] stat_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_dual   <= '0;
      stat_single <= '0;
      stat_stall  <= '0;
    end else begin
      if (pi_fire && i2_fire && stat_dual != '1) stat_dual <= stat_dual + STAT_ONE;
      if (pi_fire && !i2_fire && stat_single != '1) stat_single <= stat_single + STAT_ONE;
      if (count != 3'd0 && !pi_fire && stat_stall != '1) stat_stall <= stat_stall + STAT_ONE;
    end
  end

  assign bus.stat_dual   = stat_dual;
  assign bus.stat_single = stat_single;
  assign bus.stat_stall  = stat_stall;
`endif

endmodule

// File: tb/tb_issue2_dispatch_alloc.sv
// Testbench for issue2_dispatch_alloc: directed scenarios plus a randomized run against a
// queue-based reference model. Stats checks run when ISSUE2_ALLOC_STATS_EN is defined.
`timescale 1ns/1ps
module tb_issue2_dispatch_alloc;
  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

`ifdef ISSUE2_ALLOC_STATS_EN
  issue2_dispatch_alloc_if #(.STAT_W(32)) bus ();
  issue2_dispatch_alloc #(.FPU(0), .STAT_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));
`else
  issue2_dispatch_alloc_if bus ();
  issue2_dispatch_alloc #(.FPU(0)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif

  localparam logic [7:0] F_RAU = 8'h01, F_RBU = 8'h02, F_MEM = 8'h08, F_ALU = 8'h10;
  localparam logic [7:0] F_PIL = 8'h40, F_I2L = 8'h80;
  localparam logic [7:0] ADDI = F_RAU | F_ALU | F_PIL | F_I2L;
  localparam logic [7:0] ADD  = F_RAU | F_RBU | F_ALU | F_PIL | F_I2L;
  localparam logic [7:0] LW   = F_RAU | F_MEM | F_PIL | F_I2L;

  function automatic logic [63:0] mk(input logic [5:0] ra, input logic [5:0] rb,
                                     input logic [5:0] rc, input logic [5:0] wa,
                                     input logic [7:0] fl);
    return {fl, wa, rc, rb, ra, 26'd0, wa};
  endfunction

  // ---------------- reference model helpers (FPU=0 build) ----------------
  function automatic logic [5:0] m(input logic [5:0] a);
    return {1'b0, a[4:0]};
  endfunction

  function automatic bit blocked(input logic [63:0] e, input logic [63:0] s);
    logic [5:0] src [3];
    bit used [3];
    bit b = 0;
    src  = '{m(e[37:32]), m(e[43:38]), m(e[49:44])};
    used = '{e[56], e[57], e[58]};
    foreach (src[i]) if (used[i] && src[i] != 0 && s[src[i]]) b = 1;
    if (e[59] && s[m(e[55:50])]) b = 1;
    if (e[61] && s[m(e[37:32])]) b = 1;
    return b;
  endfunction

  function automatic bit pair_conflict(input logic [63:0] e0, input logic [63:0] e1);
    int dst0[$];
    int touch1[$];
    if ((e0[59] || e0[60]) && m(e0[55:50]) != 0) dst0.push_back(int'(m(e0[55:50])));
    if (e0[61] && m(e0[37:32]) != 0) dst0.push_back(int'(m(e0[37:32])));
    if (e1[56]) touch1.push_back(int'(m(e1[37:32])));
    if (e1[57]) touch1.push_back(int'(m(e1[43:38])));
    if (e1[58]) touch1.push_back(int'(m(e1[49:44])));
    if (e1[59] || e1[60]) touch1.push_back(int'(m(e1[55:50])));
    if (e1[61]) touch1.push_back(int'(m(e1[37:32])));
    foreach (dst0[i]) foreach (touch1[j]) if (dst0[i] == touch1[j]) return 1;
    return 0;
  endfunction

  function automatic logic [5:0] rnd_reg();
    return {1'($urandom_range(0, 1)), 2'b00, 3'($urandom_range(0, 7))};
  endfunction

  function automatic logic [63:0] rnd_entry();
    logic [7:0] fl;
    fl = 8'($urandom_range(0, 255));
    fl[6] = ($urandom_range(0, 7) != 0);
    fl[7] = ($urandom_range(0, 7) != 0);
    return {fl, rnd_reg(), rnd_reg(), rnd_reg(), rnd_reg(), 32'($urandom)};
  endfunction

  // ---------------- drive helpers ----------------
  task automatic drive_idle();
    bus.push_valid = 2'b00;
    bus.push_entry = '0;
    bus.pi_ready   = 1'b0;
    bus.i2_ready   = 1'b0;
    bus.wb_valid   = 1'b0;
    bus.wb_addr    = 6'd0;
    bus.flush      = 1'b0;
  endtask

  task automatic do_reset();
    drive_idle();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    drive_idle();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk); #1;
    n_checks++; if (bus.push_ready !== 2'b00) begin n_fail++; $display("FAIL reset_push_ready_in_rst: got %b want 00", bus.push_ready); end
    n_checks++; if (bus.pi_valid !== 1'b0) begin n_fail++; $display("FAIL reset_pi_valid: got %b want 0", bus.pi_valid); end
    n_checks++; if (bus.i2_valid !== 1'b0) begin n_fail++; $display("FAIL reset_i2_valid: got %b want 0", bus.i2_valid); end
    rst = 1'b0; #1;
    n_checks++; if (bus.push_ready !== 2'b11) begin n_fail++; $display("FAIL reset_push_ready_after: got %b want 11", bus.push_ready); end
    n_checks++; if (bus.sb_pending !== 64'd0) begin n_fail++; $display("FAIL reset_sb: got %h want 0", bus.sb_pending); end
`ifdef ISSUE2_ALLOC_STATS_EN
    n_checks++; if (bus.stat_dual !== 32'd0 || bus.stat_single !== 32'd0 || bus.stat_stall !== 32'd0) begin n_fail++; $display("FAIL reset_stats: got %0d/%0d/%0d want 0/0/0", bus.stat_dual, bus.stat_single, bus.stat_stall); end
`endif
    @(negedge clk);
  endtask

  task automatic test_dual_pair();
    logic [63:0] e0, e1;
    do_reset();
    e0 = mk(6'd0, 6'd0, 6'd0, 6'd1, ADDI);
    e1 = mk(6'd0, 6'd0, 6'd0, 6'd2, ADDI);
    bus.pi_ready = 1'b1; bus.i2_ready = 1'b1;
    bus.push_valid = 2'b11; bus.push_entry = {e1, e0}; #1;
    n_checks++; if (bus.pi_valid !== 1'b0) begin n_fail++; $display("FAIL dual_empty_pi_valid: got %b want 0", bus.pi_valid); end
    @(negedge clk); bus.push_valid = 2'b00; #1;
    n_checks++; if (bus.pi_valid !== 1'b1 || bus.i2_valid !== 1'b1) begin n_fail++; $display("FAIL dual_valids: got pi=%b i2=%b want 1/1", bus.pi_valid, bus.i2_valid); end
    n_checks++; if (bus.pi_entry !== e0 || bus.i2_entry !== e1) begin n_fail++; $display("FAIL dual_entries: got %h/%h want %h/%h", bus.pi_entry, bus.i2_entry, e0, e1); end
    @(negedge clk); #1;
    n_checks++; if (bus.pi_valid !== 1'b0 || bus.push_ready !== 2'b11) begin n_fail++; $display("FAIL dual_drained: got pi=%b pr=%b want 0/11", bus.pi_valid, bus.push_ready); end
  endtask

  task automatic test_raw_pair();
    logic [63:0] e0, e1;
    do_reset();
    e0 = mk(6'd1, 6'd2, 6'd0, 6'd3, ADD);
    e1 = mk(6'd3, 6'd5, 6'd0, 6'd4, ADD);
    bus.pi_ready = 1'b1; bus.i2_ready = 1'b1;
    bus.push_valid = 2'b11; bus.push_entry = {e1, e0};
    @(negedge clk); bus.push_valid = 2'b00; #1;
    n_checks++; if (bus.pi_valid !== 1'b1 || bus.i2_valid !== 1'b0) begin n_fail++; $display("FAIL raw_cycle1: got pi=%b i2=%b want 1/0", bus.pi_valid, bus.i2_valid); end
    @(negedge clk); #1;
    n_checks++; if (bus.pi_valid !== 1'b1 || bus.pi_entry !== e1) begin n_fail++; $display("FAIL raw_cycle2: got pi=%b entry=%h want 1/%h", bus.pi_valid, bus.pi_entry, e1); end
    @(negedge clk); #1;
    n_checks++; if (bus.pi_valid !== 1'b0) begin n_fail++; $display("FAIL raw_empty: got %b want 0", bus.pi_valid); end
  endtask

  task automatic test_load_hazard();
    logic [63:0] e0, e1, e2;
    do_reset();
    e0 = mk(6'd0, 6'd0, 6'd0, 6'd1, ADDI);
    e1 = mk(6'd2, 6'd0, 6'd0, 6'd7, LW);
    e2 = mk(6'd7, 6'd1, 6'd0, 6'd8, ADD);
    bus.pi_ready = 1'b1; bus.i2_ready = 1'b1;
    bus.push_valid = 2'b11; bus.push_entry = {e1, e0};
    @(negedge clk); bus.push_valid = 2'b00; #1;
    n_checks++; if (bus.i2_valid !== 1'b1) begin n_fail++; $display("FAIL load_i2_fire: got %b want 1", bus.i2_valid); end
    @(negedge clk); bus.push_valid = 2'b01; bus.push_entry = {64'd0, e2}; #1;
    n_checks++; if (bus.sb_pending[7] !== 1'b1) begin n_fail++; $display("FAIL load_sb_set: got %b want 1", bus.sb_pending[7]); end
    @(negedge clk); bus.push_valid = 2'b00; #1;
    n_checks++; if (bus.pi_valid !== 1'b0) begin n_fail++; $display("FAIL load_blocked1: got %b want 0", bus.pi_valid); end
    @(negedge clk); bus.wb_valid = 1'b1; bus.wb_addr = 6'd7; #1;
    n_checks++; if (bus.pi_valid !== 1'b0) begin n_fail++; $display("FAIL load_blocked_wb_cycle: got %b want 0", bus.pi_valid); end
    @(negedge clk); bus.wb_valid = 1'b0; #1;
    n_checks++; if (bus.pi_valid !== 1'b1 || bus.pi_entry !== e2 || bus.sb_pending[7] !== 1'b0) begin n_fail++; $display("FAIL load_released: got pi=%b entry=%h sb7=%b want 1/%h/0", bus.pi_valid, bus.pi_entry, bus.sb_pending[7], e2); end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [63:0] a [4];
    do_reset();
    foreach (a[i]) a[i] = mk(6'd0, 6'd0, 6'd0, 6'(i + 1), ADDI);
    bus.push_valid = 2'b11; bus.push_entry = {a[1], a[0]};
    @(negedge clk); bus.push_entry = {a[3], a[2]}; #1;
    n_checks++; if (bus.push_ready !== 2'b11) begin n_fail++; $display("FAIL bp_ready_count2: got %b want 11", bus.push_ready); end
    @(negedge clk); bus.push_valid = 2'b00; #1;
    n_checks++; if (bus.push_ready !== 2'b00 || bus.pi_valid !== 1'b1) begin n_fail++; $display("FAIL bp_full: got pr=%b pi=%b want 00/1", bus.push_ready, bus.pi_valid); end
    bus.pi_ready = 1'b1;
    @(negedge clk); bus.pi_ready = 1'b0; #1;
    n_checks++; if (bus.push_ready !== 2'b01 || bus.pi_entry !== a[1]) begin n_fail++; $display("FAIL bp_after_pop: got pr=%b entry=%h want 01/%h", bus.push_ready, bus.pi_entry, a[1]); end
  endtask

  task automatic test_flush();
    logic [63:0] a1, lw9;
    do_reset();
    a1  = mk(6'd0, 6'd0, 6'd0, 6'd1, ADDI);
    lw9 = mk(6'd2, 6'd0, 6'd0, 6'd9, LW);
    bus.pi_ready = 1'b1; bus.i2_ready = 1'b1;
    bus.push_valid = 2'b11; bus.push_entry = {lw9, a1};
    @(negedge clk); bus.push_valid = 2'b00;
    @(negedge clk); bus.pi_ready = 1'b0; bus.i2_ready = 1'b0;
    bus.push_valid = 2'b11; bus.push_entry = {mk(0, 0, 0, 11, ADDI), mk(0, 0, 0, 10, ADDI)}; #1;
    n_checks++; if (bus.sb_pending[9] !== 1'b1) begin n_fail++; $display("FAIL flush_sb9_set: got %b want 1", bus.sb_pending[9]); end
    @(negedge clk); bus.push_valid = 2'b01; bus.push_entry = {64'd0, mk(0, 0, 0, 12, ADDI)};
    @(negedge clk); bus.flush = 1'b1; bus.pi_ready = 1'b1; bus.i2_ready = 1'b1;
    bus.push_valid = 2'b11; bus.push_entry = {mk(0, 0, 0, 14, ADDI), mk(0, 0, 0, 13, ADDI)}; #1;
    n_checks++; if (bus.pi_valid !== 1'b0 || bus.i2_valid !== 1'b0 || bus.push_ready !== 2'b00) begin n_fail++; $display("FAIL flush_cycle: got pi=%b i2=%b pr=%b want 0/0/00", bus.pi_valid, bus.i2_valid, bus.push_ready); end
    @(negedge clk); bus.flush = 1'b0; bus.push_valid = 2'b00; #1;
    n_checks++; if (bus.push_ready !== 2'b11 || bus.pi_valid !== 1'b0 || bus.sb_pending[9] !== 1'b1) begin n_fail++; $display("FAIL flush_after: got pr=%b pi=%b sb9=%b want 11/0/1", bus.push_ready, bus.pi_valid, bus.sb_pending[9]); end
    bus.wb_valid = 1'b1; bus.wb_addr = 6'd9;
    @(negedge clk); bus.wb_valid = 1'b0; #1;
    n_checks++; if (bus.sb_pending[9] !== 1'b0) begin n_fail++; $display("FAIL flush_sb9_cleared: got %b want 0", bus.sb_pending[9]); end
    drive_idle();
    @(negedge clk);
  endtask

`ifdef ISSUE2_ALLOC_STATS_EN
  task automatic test_stats();
    do_reset();
    bus.push_valid = 2'b11; bus.push_entry = {mk(0, 0, 0, 2, ADDI), mk(0, 0, 0, 1, ADDI)};
    @(negedge clk); bus.push_entry = {mk(0, 0, 0, 4, ADDI), mk(0, 0, 0, 3, ADDI)};
    @(negedge clk); bus.push_valid = 2'b00; bus.pi_ready = 1'b1; bus.i2_ready = 1'b1;
    @(negedge clk); bus.i2_ready = 1'b0;
    @(negedge clk); bus.i2_ready = 1'b1;
    @(negedge clk); bus.push_valid = 2'b11; bus.push_entry = {mk(0, 0, 0, 6, ADDI), mk(0, 0, 0, 5, ADDI)};
    @(negedge clk); bus.push_entry = {mk(0, 0, 0, 8, ADDI), mk(0, 0, 0, 7, ADDI)};
    @(negedge clk); bus.push_valid = 2'b00;
    @(negedge clk); #1;
    n_checks++; if (bus.stat_dual !== 32'd3) begin n_fail++; $display("FAIL stat_dual: got %0d want 3", bus.stat_dual); end
    n_checks++; if (bus.stat_single !== 32'd2) begin n_fail++; $display("FAIL stat_single: got %0d want 2", bus.stat_single); end
    n_checks++; if (bus.stat_stall !== 32'd1) begin n_fail++; $display("FAIL stat_stall: got %0d want 1", bus.stat_stall); end
    drive_idle();
  endtask
`endif

  task automatic test_random();
    logic [63:0] q[$];
    logic [63:0] sb_m, sb_new, e0, e1, h1;
    logic [1:0]  pv, exp_pr;
    logic [5:0]  wba;
    bit pr, ir, fl, wbv, exp_pi, exp_i2;
    int n;
    do_reset();
    sb_m = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      pv  = 2'($urandom_range(0, 3));
      e0  = rnd_entry();
      e1  = rnd_entry();
      pr  = ($urandom_range(0, 3) != 0);
      ir  = ($urandom_range(0, 3) != 0);
      fl  = ($urandom_range(0, 39) == 0);
      wbv = ($urandom_range(0, 2) == 0);
      wba = rnd_reg();
      bus.push_valid = pv; bus.push_entry = {e1, e0};
      bus.pi_ready = pr; bus.i2_ready = ir; bus.flush = fl;
      bus.wb_valid = wbv; bus.wb_addr = wba;
      #1;
      n = q.size();
      exp_pr = fl ? 2'b00 : {n <= 2, n <= 3};
      exp_pi = (n >= 1) && !blocked(q[0], sb_m) && !fl;
      exp_i2 = exp_pi && pr && (n >= 2) && q[0][62] && q[1][63] &&
               !blocked(q[1], sb_m) && !pair_conflict(q[0], q[1]);
      n_checks++; if (bus.push_ready !== exp_pr) begin n_fail++; $display("FAIL rnd_push_ready cyc %0d: got %b want %b", cyc, bus.push_ready, exp_pr); end
      n_checks++; if (bus.pi_valid !== exp_pi) begin n_fail++; $display("FAIL rnd_pi_valid cyc %0d: got %b want %b", cyc, bus.pi_valid, exp_pi); end
      n_checks++; if (bus.i2_valid !== exp_i2) begin n_fail++; $display("FAIL rnd_i2_valid cyc %0d: got %b want %b", cyc, bus.i2_valid, exp_i2); end
      n_checks++; if (bus.sb_pending !== sb_m) begin n_fail++; $display("FAIL rnd_sb cyc %0d: got %h want %h", cyc, bus.sb_pending, sb_m); end
      if (exp_pi) begin
        n_checks++; if (bus.pi_entry !== q[0]) begin n_fail++; $display("FAIL rnd_pi_entry cyc %0d: got %h want %h", cyc, bus.pi_entry, q[0]); end
      end
      if (exp_i2) begin
        n_checks++; if (bus.i2_entry !== q[1]) begin n_fail++; $display("FAIL rnd_i2_entry cyc %0d: got %h want %h", cyc, bus.i2_entry, q[1]); end
      end
      sb_new = sb_m;
      if (wbv) sb_new[m(wba)] = 1'b0;
      if (exp_i2 && ir) begin
        h1 = q[1];
        if (h1[59] && m(h1[55:50]) != 0) sb_new[m(h1[55:50])] = 1'b1;
        if (h1[59] && h1[61] && m(h1[37:32]) != 0) sb_new[m(h1[37:32])] = 1'b1;
      end
      if (exp_pi && pr) void'(q.pop_front());
      if (exp_i2 && ir) void'(q.pop_front());
      if (fl) q.delete();
      else begin
        if (pv[0] && exp_pr[0]) q.push_back(e0);
        if (pv == 2'b11 && exp_pr[1]) q.push_back(e1);
      end
      sb_m = sb_new;
      @(negedge clk);
    end
    drive_idle();
  endtask

  initial begin
    rst = 1'b1;
    drive_idle();
    @(negedge clk);
    test_reset();
    test_dual_pair();
    test_raw_pair();
    test_load_hazard();
    test_backpressure();
    test_flush();
`ifdef ISSUE2_ALLOC_STATS_EN
    test_stats();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
